w0rm_bus_copy_master: RTL and testbench
=======================================

// Module: w0rm_bus_copy_master
// PURPOSE
//  Bus initiator for the W0RM peripheral memory bus: copies LEN words from SRC to DST.
//  Issues single-cycle read/write requests and waits for the responder's valid pulse.
//  Sits beside the CPU data port, ahead of an arbiter, and drives the same responders
//  (GPIO, MemoryBlock). Results return through the OR-ing bus extender tree.
// PARAMETERS
//  DATA_WIDTH   32   bus data width
//  ADDR_WIDTH   32   bus address width
//  LEN_WIDTH    16   width of the word-count register
//  ADDR_STEP    4    address increment per word, in bytes
//  TIMEOUT      255  cycles to wait for mem_valid_i before aborting (>=1)
// PORTS
//  core_clk      in   1           clock, rising edge
//  cpu_reset_n   in   1           asynchronous active-low reset
//  start_i       in   1           1-cycle pulse, sampled only in IDLE
//  src_addr_i    in   ADDR_WIDTH  first source address, latched on start
//  dst_addr_i    in   ADDR_WIDTH  first destination address, latched on start
//  len_i         in   LEN_WIDTH   word count, latched on start; 0 = no transfer
//  busy_o        out  1           high from the cycle after start until DONE/ERR
//  done_o        out  1           1-cycle pulse when the copy ends (success or error)
//  error_o       out  1           sticky timeout flag, cleared by the next accepted start
//  err_addr_o    out  ADDR_WIDTH  address of the access that timed out
//  mem_valid_o   out  1           request strobe, one cycle per access
//  mem_read_o    out  1           read request, qualified by mem_valid_o
//  mem_write_o   out  1           write request, qualified by mem_valid_o
//  mem_addr_o    out  ADDR_WIDTH  request address
//  mem_data_o    out  DATA_WIDTH  write data
//  mem_valid_i   in   1           responder completion pulse (read or write)
//  mem_data_i    in   DATA_WIDTH  read data, valid with mem_valid_i
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, counters and holding registers 0.
//  FSM: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> (RD_REQ | DONE); any WAIT -> ERR.
//  IDLE: on start_i with len_i != 0, latch src/dst/len, clear error_o, go to RD_REQ.
//    start_i with len_i == 0: clear error_o, pulse done_o next cycle, no bus activity, busy_o stays 0.
//  RD_REQ: mem_valid_o=1, mem_read_o=1, mem_addr_o=src for exactly 1 cycle, then RD_WAIT.
//  RD_WAIT: wait counter increments each cycle. On mem_valid_i, capture mem_data_i into the
//    hold register and go to WR_REQ. A response in the same cycle as the request is not accepted;
//    earliest accepted response is the cycle after mem_valid_o (1-cycle minimum latency).
//  WR_REQ: mem_valid_o=1, mem_write_o=1, mem_addr_o=dst, mem_data_o=hold, for exactly 1 cycle.
//  WR_WAIT: on mem_valid_i: src+=ADDR_STEP, dst+=ADDR_STEP, remaining-=1.
//    remaining becomes 0 -> DONE, otherwise -> RD_REQ.
//  Timeout: wait counter reaches TIMEOUT with no mem_valid_i -> ERR; err_addr_o = pending address.
//  DONE / ERR: 1 cycle each; done_o=1, busy_o falls; ERR also sets error_o. Then IDLE.
//  Minimum cost is 4 cycles per word at 1-cycle responder latency.
//  mem_read_o/mem_write_o are 0 whenever mem_valid_o is 0; mem_addr_o/mem_data_o hold their last values.
//  Addresses wrap modulo 2^ADDR_WIDTH with no error.
//  Stray mem_valid_i in IDLE/REQ/DONE/ERR is ignored. start_i while busy is ignored.
//  Exactly one access is outstanding at a time; no pipelining.
//  cpu_reset_n low mid-copy: immediate return to reset state, in-flight response is discarded.
// TESTING
//  1 src=0x4000_0000, dst=0x4000_0100, len=3, responder latency 1 -> 3 read/write pairs,
//    addresses stepping by 4, data copied exactly, done_o pulse, error_o=0, 12 busy cycles.
//  2 len=0 -> no mem_valid_o, done_o pulse 1 cycle after start, busy_o never high.
//  3 dst=0x9000_0000 (unmapped, never answers), TIMEOUT=8 -> ERR after 8 wait cycles,
//    error_o=1, err_addr_o=0x9000_0000, done_o pulse, one write request only.
//  4 Responder latency varying 1..5 per access, len=4 -> correct data, no extra requests.
//  5 Assert cpu_reset_n low during the 2nd WR_WAIT -> all outputs 0 at once;
//    a new start after reset runs cleanly.
//  6 src=0xFFFF_FFFC, len=2 -> second read at 0x0000_0000; start_i pulses while busy are ignored.

Source files
------------

// File: rtl/w0rm_bus_copy_master.sv
// W0RM bus copy master: copies a block of words from a source to a destination address,
// one read/write pair at a time, with a per-access response timeout.
module w0rm_bus_copy_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int ADDR_STEP  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  core_clk,
    input  logic                  cpu_reset_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  mem_valid_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, ERR
    } state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]         WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [LEN_WIDTH-1:0]  ONE       = LEN_WIDTH'(1);

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] src, dst, addr_last, err_addr;
    logic [DATA_WIDTH-1:0] hold, data_last;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [CW-1:0]         wait_cnt;
    logic                  error_flag;
    logic                  timed_out;

    assign timed_out  = (wait_cnt == WAIT_LAST);
    assign error_o    = error_flag;
    assign err_addr_o = err_addr;

    always_ff @(posedge core_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) state <= IDLE;
        else              state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_i) next_state = (len_i != '0) ? RD_REQ : DONE;
            RD_REQ:  next_state = RD_WAIT;
            RD_WAIT: begin
                if (mem_valid_i)    next_state = WR_REQ;
                else if (timed_out) next_state = ERR;
            end
            WR_REQ:  next_state = WR_WAIT;
            WR_WAIT: begin
                if (mem_valid_i)    next_state = (remaining == ONE) ? DONE : RD_REQ;
                else if (timed_out) next_state = ERR;
            end
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address/data buses fall back to their last driven value outside request cycles.
    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        mem_valid_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = addr_last;
        mem_data_o  = data_last;
        case (state)
            RD_REQ: begin
                busy_o      = 1'b1;
                mem_valid_o = 1'b1;
                mem_read_o  = 1'b1;
                mem_addr_o  = src;
            end
            RD_WAIT: busy_o = 1'b1;
            WR_REQ: begin
                busy_o      = 1'b1;
                mem_valid_o = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = dst;
                mem_data_o  = hold;
            end
            WR_WAIT: busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            ERR:     done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge core_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            src        <= '0;
            dst        <= '0;
            remaining  <= '0;
            hold       <= '0;
            wait_cnt   <= '0;
            addr_last  <= '0;
            data_last  <= '0;
            err_addr   <= '0;
            error_flag <= 1'b0;
        end else begin
            addr_last <= mem_addr_o;
            data_last <= mem_data_o;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        error_flag <= 1'b0;
                        if (len_i != '0) begin
                            src       <= src_addr_i;
                            dst       <= dst_addr_i;
                            remaining <= len_i;
                        end
                    end
                end
                RD_REQ, WR_REQ: wait_cnt <= '0;
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (mem_valid_i) begin
                        hold <= mem_data_i;
                    end else if (timed_out) begin
                        error_flag <= 1'b1;
                        err_addr   <= src;
                    end
                end
                WR_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (mem_valid_i) begin
                        src       <= src + STEP;
                        dst       <= dst + STEP;
                        remaining <= remaining - ONE;
                    end else if (timed_out) begin
                        error_flag <= 1'b1;
                        err_addr   <= dst;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_w0rm_bus_copy_master.sv
// Self-checking bench for w0rm_bus_copy_master: a bus responder model feeds read data,
// and a scoreboard of expected read/write addresses and copied data checks every request.
module tb_w0rm_bus_copy_master;

    localparam int TO = 8;

    logic        core_clk = 1'b0;
    logic        cpu_reset_n;
    logic        start_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, error_o;
    logic [31:0] err_addr_o;
    logic        mem_valid_o, mem_read_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_count = 0;
    int wr_count = 0;
    int last_wr_cyc = 0;
    bit rand_lat = 1'b0;

    logic [31:0] exp_rd[$];
    logic [31:0] exp_wr[$];
    logic [31:0] exp_wdata[$];

    w0rm_bus_copy_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16), .ADDR_STEP(4), .TIMEOUT(TO)
    ) dut (
        .core_clk(core_clk), .cpu_reset_n(cpu_reset_n), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_addr_o(err_addr_o),
        .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i)
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) cyc <= cyc + 1;

    // Responder: answers every request after 1 (or a random 1..5) cycles, except region 0x9xxx_xxxx.
    always begin
        int  lat;
        bit  is_rd;
        @(negedge core_clk);
        if (cpu_reset_n && mem_valid_o && mem_addr_o[31:28] != 4'h9) begin
            is_rd = mem_read_o;
            lat   = rand_lat ? int'($urandom_range(5, 1)) : 1;
            @(posedge core_clk);
            repeat (lat - 1) @(posedge core_clk);
            #1;
            mem_valid_i = 1'b1;
            if (is_rd) begin
                mem_data_i = $urandom;
                exp_wdata.push_back(mem_data_i);
            end
            @(posedge core_clk);
            #1 mem_valid_i = 1'b0;
        end
    end

    // Scoreboard: every request is popped against the expected address and copied data.
    always @(negedge core_clk) begin
        logic [31:0] e;
        if (cpu_reset_n && mem_valid_o) begin
            checks++;
            if (mem_read_o == mem_write_o) begin
                errors++;
                $display("[TB] FAIL req_kind: read=%0b write=%0b, required exactly one", mem_read_o, mem_write_o);
            end
            if (mem_read_o) begin
                rd_count++;
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL extra_read: got read at %h, required none", mem_addr_o);
                end else begin
                    e = exp_rd.pop_front();
                    if (mem_addr_o !== e) begin
                        errors++;
                        $display("[TB] FAIL rd_addr: got %h, required %h", mem_addr_o, e);
                    end
                end
            end else if (mem_write_o) begin
                wr_count++;
                last_wr_cyc = cyc;
                checks++;
                if (exp_wr.size() == 0 || exp_wdata.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL extra_write: got write at %h, required none", mem_addr_o);
                end else begin
                    e = exp_wr.pop_front();
                    if (mem_addr_o !== e) begin
                        errors++;
                        $display("[TB] FAIL wr_addr: got %h, required %h", mem_addr_o, e);
                    end
                    e = exp_wdata.pop_front();
                    checks++;
                    if (mem_data_o !== e) begin
                        errors++;
                        $display("[TB] FAIL wr_data: got %h, required %h", mem_data_o, e);
                    end
                end
            end
        end else if (cpu_reset_n) begin
            checks++;
            if (mem_read_o || mem_write_o) begin
                errors++;
                $display("[TB] FAIL idle_strobe: read=%0b write=%0b while valid=0, required 0", mem_read_o, mem_write_o);
            end
        end
    end

    task automatic push_expect(input logic [31:0] src, input logic [31:0] dst, input int len);
        for (int i = 0; i < len; i++) begin
            exp_rd.push_back(src + 32'(4 * i));
            exp_wr.push_back(dst + 32'(4 * i));
        end
    endtask

    task automatic flush_queues();
        exp_rd.delete();
        exp_wr.delete();
        exp_wdata.delete();
    endtask

    // Starts a copy and counts cycles until done_o; optional stray start pulses while busy.
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                            input bit stray, output int n, output int busy_cnt, output bit got);
        n = 0; busy_cnt = 0; got = 1'b0;
        @(posedge core_clk); #1;
        start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = len;
        @(posedge core_clk); #1;
        start_i = 1'b0; src_addr_i = $urandom; dst_addr_i = $urandom; len_i = 16'd7;
        for (int i = 1; i <= 200; i++) begin
            @(negedge core_clk);
            if (stray && i == 3) begin
                start_i = 1'b1; src_addr_i = 32'h5555_0000; dst_addr_i = 32'h6666_0000;
            end
            if (stray && i == 5) start_i = 1'b0;
            if (done_o) begin
                n = i; got = 1'b1;
                break;
            end
            if (busy_o) busy_cnt++;
        end
        start_i = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL done_timeout: no done_o within 200 cycles, required a pulse");
        end
    endtask

    task automatic check_queues_empty(input string tag);
        checks++;
        if (exp_rd.size() != 0 || exp_wr.size() != 0 || exp_wdata.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_pending: rd=%0d wr=%0d data=%0d left, required 0",
                     tag, exp_rd.size(), exp_wr.size(), exp_wdata.size());
        end
    endtask

    task automatic test_reset();
        cpu_reset_n = 1'b0; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
        mem_valid_i = 1'b0; mem_data_i = '0;
        #12;
        checks++;
        if ({busy_o, done_o, error_o, mem_valid_o, mem_read_o, mem_write_o} !== 6'b0 ||
            err_addr_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_data_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: busy=%0b done=%0b err=%0b valid=%0b addr=%h data=%h, required all 0",
                     busy_o, done_o, error_o, mem_valid_o, mem_addr_o, mem_data_o);
        end
        @(negedge core_clk);
        cpu_reset_n = 1'b1;
        repeat (2) @(negedge core_clk);
    endtask

    task automatic test_basic_copy();
        int n, b; bit got;
        rand_lat = 1'b0;
        push_expect(32'h4000_0000, 32'h4000_0100, 3);
        run_copy(32'h4000_0000, 32'h4000_0100, 16'd3, 1'b0, n, b, got);
        checks++;
        if (n != 13 || b != 12) begin
            errors++;
            $display("[TB] FAIL basic_timing: done at %0d busy %0d, required 13 and 12", n, b);
        end
        checks++;
        if (error_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_error: error_o=%0b, required 0", error_o);
        end
        @(negedge core_clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done_width: done=%0b busy=%0b after pulse, required 0 0", done_o, busy_o);
        end
        check_queues_empty("basic");
    endtask

    task automatic test_zero_len();
        int n, b, r0; bit got;
        r0 = rd_count + wr_count;
        run_copy(32'h4000_0000, 32'h4000_0100, 16'd0, 1'b0, n, b, got);
        checks++;
        if (n != 1 || b != 0 || (rd_count + wr_count) != r0) begin
            errors++;
            $display("[TB] FAIL zero_len: done at %0d busy %0d requests %0d, required 1 0 0",
                     n, b, rd_count + wr_count - r0);
        end
    endtask

    task automatic test_timeout();
        int n, b; bit got;
        rand_lat = 1'b0;
        exp_rd.push_back(32'h4000_0000);
        exp_wr.push_back(32'h9000_0000);
        run_copy(32'h4000_0000, 32'h9000_0000, 16'd2, 1'b0, n, b, got);
        checks++;
        if (n != 12 || b != 11 || (cyc - last_wr_cyc) != TO + 1) begin
            errors++;
            $display("[TB] FAIL timeout_timing: done at %0d busy %0d gap %0d, required 12 11 %0d",
                     n, b, cyc - last_wr_cyc, TO + 1);
        end
        checks++;
        if (error_o !== 1'b1 || err_addr_o !== 32'h9000_0000) begin
            errors++;
            $display("[TB] FAIL timeout_flag: error=%0b err_addr=%h, required 1 90000000", error_o, err_addr_o);
        end
        repeat (3) @(negedge core_clk);
        checks++;
        if (error_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: error=%0b done=%0b, required 1 0", error_o, done_o);
        end
        check_queues_empty("timeout");
    endtask

    task automatic test_random_latency();
        int n, b, r0, w0; bit got;
        rand_lat = 1'b1;
        r0 = rd_count; w0 = wr_count;
        push_expect(32'h4000_1000, 32'h4000_2000, 4);
        run_copy(32'h4000_1000, 32'h4000_2000, 16'd4, 1'b0, n, b, got);
        checks++;
        if (error_o !== 1'b0 || (rd_count - r0) != 4 || (wr_count - w0) != 4) begin
            errors++;
            $display("[TB] FAIL random_lat: error=%0b reads=%0d writes=%0d, required 0 4 4",
                     error_o, rd_count - r0, wr_count - w0);
        end
        checks++;
        if (b < 16 || b > 48) begin
            errors++;
            $display("[TB] FAIL random_lat_busy: busy %0d cycles, required 16..48", b);
        end
        rand_lat = 1'b0;
        repeat (8) @(negedge core_clk);
        check_queues_empty("random_lat");
    endtask

    task automatic test_mid_reset();
        int n, b, w0; bit got, seen;
        rand_lat = 1'b0;
        w0 = wr_count; seen = 1'b0;
        push_expect(32'h4000_3000, 32'h4000_4000, 3);
        @(posedge core_clk); #1;
        start_i = 1'b1; src_addr_i = 32'h4000_3000; dst_addr_i = 32'h4000_4000; len_i = 16'd3;
        @(posedge core_clk); #1 start_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge core_clk);
            if (wr_count == w0 + 2) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL mid_reset_wait: second write not seen, required one");
        end
        @(posedge core_clk); #1;
        cpu_reset_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, error_o, mem_valid_o, mem_read_o, mem_write_o} !== 6'b0 ||
            mem_addr_o !== 32'h0 || mem_data_o !== 32'h0 || err_addr_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: busy=%0b done=%0b valid=%0b addr=%h data=%h, required all 0",
                     busy_o, done_o, mem_valid_o, mem_addr_o, mem_data_o);
        end
        repeat (3) @(negedge core_clk);
        flush_queues();
        cpu_reset_n = 1'b1;
        repeat (2) @(negedge core_clk);
        push_expect(32'h4000_6000, 32'h4000_7000, 2);
        run_copy(32'h4000_6000, 32'h4000_7000, 16'd2, 1'b0, n, b, got);
        checks++;
        if (n != 9 || b != 8 || error_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_copy: done at %0d busy %0d error %0b, required 9 8 0", n, b, error_o);
        end
        check_queues_empty("post_reset");
    endtask

    task automatic test_wrap_and_stray_start();
        int n, b; bit got;
        rand_lat = 1'b0;
        exp_rd.push_back(32'hFFFF_FFFC); exp_rd.push_back(32'h0000_0000);
        exp_wr.push_back(32'h4000_5000); exp_wr.push_back(32'h4000_5004);
        run_copy(32'hFFFF_FFFC, 32'h4000_5000, 16'd2, 1'b1, n, b, got);
        checks++;
        if (n != 9 || b != 8 || error_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_stray: done at %0d busy %0d error %0b, required 9 8 0", n, b, error_o);
        end
        repeat (4) @(negedge core_clk);
        checks++;
        if (busy_o !== 1'b0 || mem_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_stray_idle: busy=%0b valid=%0b after copy, required 0 0", busy_o, mem_valid_o);
        end
        check_queues_empty("wrap");
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_timeout();
        test_random_latency();
        test_mid_reset();
        test_wrap_and_stray_start();
        repeat (4) @(negedge core_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
